// File: rtl/ttl194_universal_register.sv
// ----------------------------------------------------------------------------
// ttl194_universal_register
//
// WIDTH-bit universal shift register in the 74x194 family style, widened, with
// a selectable inverting data path. One rising-edge clock domain, asynchronous
// active-low clear. Supported actions are hold, ones-complement in place,
// shift right, shift left and parallel load.
//
// Ports
//   CLK     in   1      rising-edge clock
//   CLR_n   in   1      asynchronous active-low clear (Q -> 0)
//   S       in   2      mode: 00 hold/complement, 01 shift right,
//                             10 shift left, 11 load
//   INV     in   1      invert load data and serial inputs; in mode 00 it
//                       selects complement instead of hold
//   D       in   WIDTH  parallel load data
//   DSR     in   1      serial input for shift right (enters bit 0)
//   DSL     in   1      serial input for shift left (enters bit WIDTH-1)
//   Q       out  WIDTH  register contents
//   QR_OUT  out  1      Q[WIDTH-1], the bit a right shift pushes out
//   QL_OUT  out  1      Q[0], the bit a left shift pushes out
// ----------------------------------------------------------------------------
module ttl194_universal_register #(
    parameter int WIDTH             = 8,
    // Clock-to-Q / clear-to-Q delay in ns. The delay belongs to timing
    // constraints and back-annotation; the synthesizable model is zero-delay.
    parameter int PROPAGATION_DELAY = 10
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic [1:0]       S,
    input  logic             INV,
    input  logic [WIDTH-1:0] D,
    input  logic             DSR,
    input  logic             DSL,
    output logic [WIDTH-1:0] Q,
    output logic             QR_OUT,
    output logic             QL_OUT
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 2) begin : g_width_check
        $error("ttl194_universal_register: WIDTH must be >= 2 (got %0d)", WIDTH);
    end
    if (PROPAGATION_DELAY < 0) begin : g_delay_check
        $error("ttl194_universal_register: PROPAGATION_DELAY must be >= 0 (got %0d)",
               PROPAGATION_DELAY);
    end

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             dsr_x;
    logic             dsl_x;

    // Inverting data path applied to the serial inputs.
    assign dsr_x = DSR ^ INV;
    assign dsl_x = DSL ^ INV;

    always_comb begin
        // NOTE: default assignment first so every path drives q_d; without it
        // an uncovered branch would infer a latch.
        q_d = q_q;
        case (S)
            MODE_HOLD: q_d = INV ? ~q_q : q_q;
            MODE_SHR:  q_d = {q_q[WIDTH-2:0], dsr_x};
            MODE_SHL:  q_d = {dsl_x, q_q[WIDTH-1:1]};
            MODE_LOAD: q_d = D ^ {WIDTH{INV}};
            // An unknown mode select poisons the word rather than guessing.
            default:   q_d = {WIDTH{1'bx}};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all flops
    // sample their next-state values from the same edge.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Serial outputs are taps of the stored word, not separate flops.
    assign Q      = q_q;
    assign QR_OUT = q_q[WIDTH-1];
    assign QL_OUT = q_q[0];

endmodule

// File: tb/tb_ttl194_universal_register.sv
// ----------------------------------------------------------------------------
// tb_ttl194_universal_register
//
// Directed bench for ttl194_universal_register (WIDTH=8). 100 ns clock with
// rising edges at 50, 150, ...; inputs change on the falling edge and outputs
// are sampled 50 ns after each rising edge (i.e. on the falling edge).
// ----------------------------------------------------------------------------
module tb_ttl194_universal_register;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             CLR_n;
    logic [1:0]       S;
    logic             INV;
    logic [WIDTH-1:0] D;
    logic             DSR;
    logic             DSL;
    logic [WIDTH-1:0] Q;
    logic             QR_OUT;
    logic             QL_OUT;

    int checks   = 0;
    int failures = 0;

    ttl194_universal_register #(
        .WIDTH             (WIDTH),
        .PROPAGATION_DELAY (10)
    ) dut (
        .CLK    (CLK),
        .CLR_n  (CLR_n),
        .S      (S),
        .INV    (INV),
        .D      (D),
        .DSR    (DSR),
        .DSL    (DSL),
        .Q      (Q),
        .QR_OUT (QR_OUT),
        .QL_OUT (QL_OUT)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_q(input string tag, input logic [7:0] expected);
        check({tag, ".q"},  Q,      expected);
        check({tag, ".qr"}, QR_OUT, {7'b0, expected[7]});
        check({tag, ".ql"}, QL_OUT, {7'b0, expected[0]});
    endtask

    // One rising edge, then sample on the following falling edge.
    task automatic tick;
        @(posedge CLK);
        #50;
    endtask

    task automatic load(input logic [7:0] value);
        S   = 2'b11;
        INV = 1'b0;
        D   = value;
        tick();
    endtask

    initial begin
        CLR_n = 1'b0;
        S     = 2'b11;
        INV   = 1'b0;
        D     = 8'hA5;
        DSR   = 1'b0;
        DSL   = 1'b0;

        // Reset state, with a load request pending during clear.
        tick();
        check_q("reset", 8'h00);

        // 1: asynchronous clear mid-cycle, no clock edge involved.
        CLR_n = 1'b1;
        load(8'hA5);
        check_q("load_a5", 8'hA5);
        #10 CLR_n = 1'b0;
        #30;
        check_q("async_clr", 8'h00);
        // Edge while clear is still low is ignored despite S=11, D=A5.
        @(negedge CLK);
        check_q("clr_edge_ignored", 8'h00);
        CLR_n = 1'b1;

        // 2: load, straight and inverted.
        load(8'h3C);
        check_q("load_3c", 8'h3C);
        INV = 1'b1;
        tick();
        check_q("load_inv_3c", 8'hC3);

        // 3: shift right, then shift right with inverted serial input.
        load(8'h81);
        S   = 2'b01;
        DSR = 1'b0;
        INV = 1'b0;
        tick();
        check_q("shr_dsr0", 8'h02);
        DSR = 1'b1;
        INV = 1'b1;
        tick();
        check_q("shr_dsr1_inv", 8'h04);

        // 4: shift left, then hold for three edges.
        load(8'h81);
        S   = 2'b10;
        DSL = 1'b1;
        INV = 1'b0;
        tick();
        check_q("shl_dsl1", 8'hC0);
        S = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_q("hold", 8'hC0);
        end

        // 5: complement is self-inverse.
        load(8'h5A);
        S   = 2'b00;
        INV = 1'b1;
        tick();
        check_q("cpl_1", 8'hA5);
        tick();
        check_q("cpl_2", 8'h5A);

        // 6: clear held across two edges, then release and shift in a one.
        load(8'hFF);
        check_q("load_ff", 8'hFF);
        CLR_n = 1'b0;
        tick();
        check_q("clr_hold_1", 8'h00);
        tick();
        check_q("clr_hold_2", 8'h00);
        CLR_n = 1'b1;
        S     = 2'b01;
        DSR   = 1'b1;
        INV   = 1'b0;
        tick();
        check_q("release_shr", 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
